// File: rtl/sreg_arbiter.sv
// Frame scheduler for a shift register shared by a TX requester (parallel in, serial out)
// and an RX requester (serial in, parallel out), with alternating-priority arbitration.
module sreg_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_req,
    input  logic             sinp,
    output logic             sout,
    output logic             sout_en,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_RX   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_tx_q, last_tx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic             last_bit;
    logic             grant_tx;
    logic             grant_rx;
    logic [WIDTH-1:0] rx_shift;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign rx_shift = {shreg_q[WIDTH-2:0], sinp};

    // RX only blocks TX when it is contending and TX had the previous grant.
    assign tx_ready = (state_q == S_IDLE) && !(rx_req && last_tx_q);
    assign grant_tx = tx_valid && tx_ready;
    assign grant_rx = (state_q == S_IDLE) && rx_req && !grant_tx;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        last_tx_d  = last_tx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_tx) begin
                    shreg_d   = tx_data;
                    cnt_d     = '0;
                    last_tx_d = 1'b1;
                    state_d   = S_TX;
                end else if (grant_rx) begin
                    shreg_d   = '0;
                    cnt_d     = '0;
                    last_tx_d = 1'b0;
                    state_d   = S_RX;
                end
            end
            S_TX: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = S_IDLE;
                end
            end
            S_RX: begin
                shreg_d = rx_shift;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    rx_data_d  = rx_shift;
                    rx_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            last_tx_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            last_tx_q  <= last_tx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sout     = (state_q == S_TX) && shreg_q[WIDTH-1];
    assign sout_en  = (state_q == S_TX);
    assign busy     = (state_q != S_IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_sreg_arbiter.sv
// Directed bench for sreg_arbiter (WIDTH=4): TX, RX, alternating arbitration,
// back-to-back frames, asynchronous abort and an RX frame with mid-frame request changes.
module tb_sreg_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rx_req;
    logic             sinp;
    logic             sout;
    logic             sout_en;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             busy;

    int passed = 0;
    int total  = 0;

    sreg_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_req   (rx_req),
        .sinp     (sinp),
        .sout     (sout),
        .sout_en  (sout_en),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs are then changed 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] word;

        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_req = 1'b0; sinp = 1'b0;
        #12;
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_sout_en", 32'(sout_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        tick();
        reset = 1'b0;

        // Plain TX frame 1011
        tx_valid = 1'b1; tx_data = 4'b1011; #1;
        check("t1_ready_pre", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0; tx_data = 4'b0000;
        word = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            #1;
            $display("t1 bit %0d sout=%0b sout_en=%0b", i, sout, sout_en);
            check("t1_sout", 32'(sout), 32'(word[3-i]));
            check("t1_sout_en", 32'(sout_en), 32'd1);
            check("t1_busy", 32'(busy), 32'd1);
            check("t1_ready", 32'(tx_ready), 32'd0);
            tick();
        end
        check("t1_end_busy", 32'(busy), 32'd0);
        check("t1_end_ready", 32'(tx_ready), 32'd1);
        check("t1_end_sout_en", 32'(sout_en), 32'd0);

        // RX frame 0011; last grant was TX so RX contention would block TX
        rx_req = 1'b1; #1;
        check("t2_ready_pre", 32'(tx_ready), 32'd0);
        tick();
        rx_req = 1'b0;
        word = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            sinp = word[3-i]; #1;
            check("t2_sout", 32'(sout), 32'd0);
            check("t2_sout_en", 32'(sout_en), 32'd0);
            check("t2_busy", 32'(busy), 32'd1);
            check("t2_rx_valid_mid", 32'(rx_valid), 32'd0);
            tick();
        end
        sinp = 1'b1;
        $display("t2 rx_valid=%0b rx_data=%b", rx_valid, rx_data);
        check("t2_rx_valid", 32'(rx_valid), 32'd1);
        check("t2_rx_data", 32'(rx_data), 32'b0011);
        check("t2_busy_end", 32'(busy), 32'd0);
        tick();
        check("t2_rx_valid_pulse", 32'(rx_valid), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("t2_rx_data_held", 32'(rx_data), 32'b0011);
        check("t2_sout_idle", 32'(sout), 32'd0);

        // Continuous contention from reset: TX, RX, TX, RX with one IDLE cycle between
        reset = 1'b1; #2; reset = 1'b0;
        tx_valid = 1'b1; rx_req = 1'b1; tx_data = 4'b1111; sinp = 1'b0; #1;
        for (int f = 0; f < 4; f++) begin
            check("t3_idle_busy", 32'(busy), 32'd0);
            check("t3_idle_ready", 32'(tx_ready), (f % 2 == 0) ? 32'd1 : 32'd0);
            if (f == 2) check("t3_rx_valid", 32'(rx_valid), 32'd1);
            tick();
            for (int i = 0; i < 4; i++) begin
                $display("t3 frame %0d cycle %0d busy=%0b sout_en=%0b", f, i, busy, sout_en);
                check("t3_busy", 32'(busy), 32'd1);
                check("t3_sout_en", 32'(sout_en), (f % 2 == 0) ? 32'd1 : 32'd0);
                check("t3_sout", 32'(sout), (f % 2 == 0) ? 32'd1 : 32'd0);
                tick();
            end
        end
        tx_valid = 1'b0; rx_req = 1'b0; #1;
        check("t3_final_idle", 32'(busy), 32'd0);
        check("t3_final_rx_valid", 32'(rx_valid), 32'd1);
        tick();

        // Back-to-back TX 1000 then 0001 with tx_valid held
        tx_valid = 1'b1; tx_data = 4'b1000;
        tick();
        tx_data = 4'b0001;
        word = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4a_sout", 32'(sout), 32'(word[3-i]));
            check("t4a_sout_en", 32'(sout_en), 32'd1);
            tick();
        end
        check("t4_gap_sout_en", 32'(sout_en), 32'd0);
        check("t4_gap_busy", 32'(busy), 32'd0);
        tick();
        tx_valid = 1'b0;
        word = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4b_sout", 32'(sout), 32'(word[3-i]));
            check("t4b_sout_en", 32'(sout_en), 32'd1);
            tick();
        end
        check("t4_end_busy", 32'(busy), 32'd0);

        // Asynchronous abort after two bits of 1100
        tx_valid = 1'b1; tx_data = 4'b1100;
        tick();
        tx_valid = 1'b0;
        check("t5_bit0", 32'(sout), 32'd1);
        tick();
        check("t5_bit1", 32'(sout), 32'd1);
        tick();
        reset = 1'b1; #1;
        check("t5_abort_sout", 32'(sout), 32'd0);
        check("t5_abort_sout_en", 32'(sout_en), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_no_rx_valid", 32'(rx_valid), 32'd0);
            tick();
        end
        tx_valid = 1'b1; tx_data = 4'b0110; #1;
        check("t5_ready", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        word = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_sout", 32'(sout), 32'(word[3-i]));
            check("t5_sout_en", 32'(sout_en), 32'd1);
            tick();
        end
        check("t5_end_busy", 32'(busy), 32'd0);

        // RX frame 1001 with rx_req dropped and tx_valid raised mid-frame
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
        word = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            sinp = word[3-i];
            if (i == 1) begin
                tx_valid = 1'b1; tx_data = 4'b1010;
            end
            #1;
            check("t6_busy", 32'(busy), 32'd1);
            check("t6_sout_en", 32'(sout_en), 32'd0);
            check("t6_ready", 32'(tx_ready), 32'd0);
            tick();
        end
        $display("t6 rx_valid=%0b rx_data=%b", rx_valid, rx_data);
        check("t6_rx_valid", 32'(rx_valid), 32'd1);
        check("t6_rx_data", 32'(rx_data), 32'b1001);
        check("t6_idle_ready", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        check("t6_tx_sout_en", 32'(sout_en), 32'd1);
        check("t6_tx_sout", 32'(sout), 32'd1);
        check("t6_rx_valid_pulse", 32'(rx_valid), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t6_end_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sreg_arbiter.md
Name: sreg_arbiter

Overview:
Frame-level scheduler for a WIDTH-bit shift register shared between two requesters. A transmit requester hands over a parallel word that is shifted out serially, MSB first. A receive requester asks for a frame of WIDTH serial bits to be shifted in and returned as a parallel word. The block contains the shift register, bit counter, arbitration logic and sequencing FSM. It sits between host-side logic and the serial pin pair.

Parameters:
WIDTH, 4, frame length in bits and width of the shift register and data ports (WIDTH >= 2).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
tx_valid  in  1  TX requester holds a word.
tx_data  in  WIDTH  word to transmit; sampled only on TX handshake.
tx_ready  out  1  combinational; TX word accepted at the edge where tx_valid && tx_ready.
rx_req  in  1  RX requester asks for one frame.
sinp  in  1  serial input; sampled only in RX state.
sout  out  1  serial output; equals the shift register MSB in TX state, 0 otherwise.
sout_en  out  1  high exactly while sout carries frame bits.
rx_valid  out  1  registered one-cycle pulse; rx_data is new.
rx_data  out  WIDTH  last received word; held until the next RX frame completes.
busy  out  1  high when state != IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state=IDLE, shreg=0, cnt=0, last_grant=RX (so TX wins the first tie), rx_data=0, rx_valid=0. Outputs then read sout=0, sout_en=0, busy=0, and tx_ready=1 unless rx_req wins per the rule below. An aborted frame produces no rx_valid and no further sout bits.
- FSM states: IDLE, TX, RX. cnt width is $clog2(WIDTH)+1.
- Arbitration, evaluated in IDLE only:
  - Both tx_valid and rx_req high: grant the requester that is NOT last_grant.
  - Only one requesting: grant it.
  - last_grant updates on every grant.
- tx_ready = (state==IDLE) && !(rx_req && last_grant==TX). It is independent of tx_valid.
- TX grant at edge N (tx_valid && tx_ready): shreg<=tx_data, cnt<=0, state<=TX.
  - Cycles N+1..N+WIDTH: sout=shreg[WIDTH-1], sout_en=1. Each edge shifts shreg left (fill 0) and increments cnt.
  - At the edge where cnt==WIDTH-1, state<=IDLE.
  - Result: tx_data[WIDTH-1] down to tx_data[0] appear on consecutive cycles.
- RX grant at edge N (rx_req, granted, no TX handshake): shreg<=0, cnt<=0, state<=RX.
  - Edges N+1..N+WIDTH sample sinp: shreg<={shreg[WIDTH-2:0], sinp}. The first sampled bit becomes the MSB.
  - At edge N+WIDTH: rx_data<={shreg[WIDTH-2:0], sinp}, rx_valid<=1 for one cycle, state<=IDLE.
- rx_req and tx_valid are ignored outside IDLE. Dropping rx_req mid-frame does not abort the frame. tx_data changes during TX have no effect.
- Minimum one IDLE cycle between consecutive frames. A request pending at the end of a frame is granted at the first edge in IDLE.
- sinp is ignored in IDLE and TX. sout is 0 in IDLE and RX.

Test Plan:
1. WIDTH=4, after reset, tx_valid=1 with tx_data=4'b1011 at edge N -> tx_ready=1 before N; sout=1,0,1,1 with sout_en=1 in cycles N+1..N+4; busy=1 and tx_ready=0 during that window; IDLE and tx_ready=1 at N+5.
2. rx_req pulse granted at edge N, sinp=0,0,1,1 before edges N+1..N+4 -> rx_data=4'b0011 and rx_valid=1 for the single cycle after N+4; sout=0 throughout; rx_data still 0011 ten cycles later.
3. tx_valid=1 and rx_req=1 held continuously from reset -> grants alternate TX, RX, TX, RX. Each frame is followed by exactly one IDLE cycle. tx_ready=0 in IDLE cycles where RX wins.
4. Back-to-back TX 4'b1000 then 4'b0001 with tx_valid held -> sout 1,0,0,0, one IDLE cycle with sout_en=0, then 0,0,0,1.
5. Reset asserted asynchronously mid-TX after 2 bits of 4'b1100 -> sout=0, sout_en=0, busy=0 immediately. After release, rx_valid stays 0 and a new TX 4'b0110 transmits cleanly.
6. RX frame with rx_req dropped after grant and tx_valid raised mid-frame, sinp=1,0,0,1 -> frame completes with rx_data=4'b1001 and rx_valid pulse; TX granted only after return to IDLE.
